cla_pg_stage: RTL and testbench
===============================

// Module: cla_pg_stage
// PURPOSE
//  Registered operand/propagate-generate stage directly upstream of the 4-bit carry-lookahead carry block.
//  - Accepts operand pairs (a, b, cin) over a valid/ready handshake.
//  - Computes per-bit propagate p = a ^ b and generate g = a & b.
//  - Presents p, g and c0 = cin registered to the carry block.
//  - A 2-entry skid buffer decouples in_ready from out_ready, so no combinational ready path crosses the stage.
// PARAMETERS
//  WIDTH  4  operand width; p[i]/g[i] drive carry-block inputs p(i+1)/g(i+1); the carry block requires 4
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      upstream operands valid
//  in_ready   out  1      stage can accept operands this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in
//  out_valid  out  1      p/g/c0 valid to carry block
//  out_ready  in   1      downstream (carry/sum stage) accepts this cycle
//  p          out  WIDTH  propagate, a ^ b
//  g          out  WIDTH  generate, a & b
//  c0         out  1      registered cin
// BEHAVIOUR
//  Reset (rst_n=0, async, takes effect immediately):
//  - State = EMPTY; out_valid=0, in_ready=0 while rst_n low, in_ready=1 from first clk after release.
//  - p=0, g=0, c0=0; skid register cleared.
//  Transfers: in_xfer = in_valid & in_ready; out_xfer = out_valid & out_ready.
//  Storage:
//  - MAIN register drives outputs.
//  - SKID register holds one overflow entry.
//  - Each entry stores {p,g,c0} computed at capture time from a,b,cin.
//  States:
//  - EMPTY: out_valid=0, in_ready=1; in_xfer -> MAIN, go ONE.
//  - ONE:   out_valid=1, in_ready=1.
//    - in_xfer & out_xfer: MAIN<=new, stay ONE.
//    - in_xfer only: SKID<=new, go TWO.
//    - out_xfer only: go EMPTY.
//    - neither: hold.
//  - TWO:   out_valid=1, in_ready=0.
//    - out_xfer: MAIN<=SKID, go ONE.
//    - else: hold.
//    - in_valid is ignored (no in_xfer possible).
//  Timing and ordering:
//  - in_ready and out_valid are pure functions of state (registered), never of same-cycle inputs.
//  - Latency: operands accepted at edge N appear on p/g/c0 with out_valid=1 after edge N when the stage was empty.
//  - Throughput: 1 transfer/cycle sustained while out_ready=1.
//  - Order preserved strictly FIFO; no entry dropped or duplicated.
//  - Outputs stable while out_valid=1 & out_ready=0 (handshake hold rule).
//  - Inputs a, b, cin are sampled only on in_xfer; values in other cycles are don't-care.
//  Arithmetic: bitwise only, no carries formed here; p,g exactly WIDTH bits, no truncation.
//  Reset mid-operation: all pending entries discarded; out_valid drops asynchronously; no stale entry emerges after release.
//  Illegal condition: state encoding 2'b11 recovers to EMPTY on the next clock.
// TESTING
//  1 Reset: assert rst_n=0 mid-stream in state TWO -> out_valid=0, p=g=0, c0=0 immediately; first post-release output is a new operand.
//  2 Single op: a=4'b1011, b=4'b0110, cin=1, out_ready=1 -> next cycle p=4'b1101, g=4'b0010, c0=1, out_valid=1, then EMPTY.
//  3 Streaming: 16 back-to-back ops (a=i, b=15-i, cin=i[0]), out_ready=1 -> 16 outputs, one per cycle, p=4'b1111, g=0, in order.
//  4 Backpressure: out_ready=0, send 3 ops -> 2 accepted, in_ready=0 after 2nd, outputs frozen on op0; raise out_ready -> op0, op1, op2 in order.
//  5 Simultaneous: in ONE with in_xfer & out_xfer every cycle -> state stays ONE, never TWO, no bubbles.
//  6 Exhaustive: all 512 (a,b,cin) through the stage into the carry block -> c1..c4 match (a+b+cin) carries.

Source files
------------

// File: rtl/cla_pg_stage_if.sv
// Operand/propagate-generate handshake bundle between upstream, this stage and the carry block.
// Latency: n/a (wiring only).
// Backpressure: in_ready/out_ready travel in the opposite direction to the valid/data they qualify.
interface cla_pg_stage_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic             c0;

  // Upstream operand source plus downstream ready (testbench / surrounding datapath)
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, p, g, c0
  );

  // The pg stage itself
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, p, g, c0
  );
endinterface

// File: rtl/cla_pg_stage.sv
// Registered propagate/generate stage feeding the 4-bit carry-lookahead block.
// Latency: 1 cycle from accepted operands to p/g/c0 when empty; 1 op/cycle sustained.
// Backpressure: 2-entry skid (MAIN + SKID); in_ready/out_valid are registered, no comb ready path.
module cla_pg_stage #(
  parameter int WIDTH = 4
) (
  input logic          clk,
  input logic          rst_n,
  cla_pg_stage_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b10
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic             c0;
  } entry_t;

  state_t state;
  entry_t main_ent;
  entry_t skid_ent;
  entry_t new_ent;
  logic   ready_reg;
  logic   valid_reg;
  logic   in_xfer;
  logic   out_xfer;

  // Handshakes use only the registered ready/valid, so no input reaches another output combinationally.
  assign in_xfer  = bus.in_valid & ready_reg;
  assign out_xfer = valid_reg & bus.out_ready;

  // Bitwise propagate/generate of the operands currently on the input; only captured on in_xfer.
  always_comb begin
    new_ent    = '0;
    new_ent.p  = bus.a ^ bus.b;
    new_ent.g  = bus.a & bus.b;
    new_ent.c0 = bus.cin;
  end

  assign bus.in_ready  = ready_reg;
  assign bus.out_valid = valid_reg;
  assign bus.p         = main_ent.p;
  assign bus.g         = main_ent.g;
  assign bus.c0        = main_ent.c0;

  // Skid FSM: MAIN always drives the outputs, SKID absorbs the one entry accepted while MAIN is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      main_ent  <= '0;
      skid_ent  <= '0;
      ready_reg <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          ready_reg <= 1'b1;
          valid_reg <= 1'b0;
          if (in_xfer) begin
            main_ent  <= new_ent;
            valid_reg <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          ready_reg <= 1'b1;
          valid_reg <= 1'b1;
          if (in_xfer && out_xfer) begin
            main_ent <= new_ent;
          end else if (in_xfer) begin
            skid_ent  <= new_ent;
            ready_reg <= 1'b0;
            state     <= TWO;
          end else if (out_xfer) begin
            valid_reg <= 1'b0;
            state     <= EMPTY;
          end
        end
        TWO: begin
          ready_reg <= 1'b0;
          valid_reg <= 1'b1;
          if (out_xfer) begin
            main_ent  <= skid_ent;
            ready_reg <= 1'b1;
            state     <= ONE;
          end
        end
        default: begin
          // Unreachable encoding: drop whatever is held and come back empty and ready.
          main_ent  <= '0;
          skid_ent  <= '0;
          ready_reg <= 1'b1;
          valid_reg <= 1'b0;
          state     <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_pg_stage.sv
// Bench for cla_pg_stage: directed vectors, expected results queued at acceptance, monitor pops on output transfer.
// Latency: n/a.
// Backpressure: exercised by driving out_ready low while streaming.
module tb_cla_pg_stage;

  localparam int WIDTH = 4;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] ep;
    logic [3:0] eg;
    logic       ec0;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   n_out;
  int   stalls;
  exp_t sb[$];

  cla_pg_stage_if #(.WIDTH(WIDTH)) bus ();

  cla_pg_stage #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Carries of the true sum a+b+cin into bits 1..4
  function automatic logic [3:0] sum_carry(input logic [3:0] a, input logic [3:0] b, input logic cin);
    logic [3:0] r;
    int s;
    int mask;
    for (int i = 0; i < 4; i++) begin
      mask = (1 << (i + 1)) - 1;
      s    = (int'(a) & mask) + (int'(b) & mask) + int'(cin);
      r[i] = s[i + 1];
    end
    return r;
  endfunction

  // Lookahead carry block fed by the stage outputs
  function automatic logic [3:0] la_carry(input logic [3:0] p, input logic [3:0] g, input logic c0);
    logic [3:0] r;
    logic c;
    c = c0;
    for (int i = 0; i < 4; i++) begin
      c    = g[i] | (p[i] & c);
      r[i] = c;
    end
    return r;
  endfunction

  // Output monitor: pops one expectation per out transfer and checks the stall hold rule
  logic       held;
  logic [8:0] held_val;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (bus.out_valid && !bus.out_ready) begin
        if (held) chk("hold_stable", {bus.p, bus.g, bus.c0}, held_val);
        held     = 1'b1;
        held_val = {bus.p, bus.g, bus.c0};
      end else begin
        held = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual p=%0h g=%0h c0=%0b required none", bus.p, bus.g, bus.c0);
        end else begin
          e = sb.pop_front();
          chk("out_p", bus.p, e.ep);
          chk("out_g", bus.g, e.eg);
          chk("out_c0", bus.c0, e.ec0);
          chk("carries", la_carry(bus.p, bus.g, bus.c0), sum_carry(e.a, e.b, e.cin));
        end
      end
    end
  end

  // Present one operand set (called at posedge+1) and hold it until accepted; push its expectation then.
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic cin,
                      input logic [3:0] ep, input logic [3:0] eg);
    exp_t e;
    bit done;
    done         = 1'b0;
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        e.a = a; e.b = b; e.cin = cin; e.ep = ep; e.eg = eg; e.ec0 = cin;
        sb.push_back(e);
        done = 1'b1;
      end else begin
        stalls++;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual not_accepted required accepted a=%0h b=%0h", a, b);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || bus.out_valid) && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_queue_empty", sb.size(), 0);
  endtask

  initial begin
    int base;
    logic [3:0] av;
    logic [3:0] bv;
    checks        = 0;
    errors        = 0;
    n_out         = 0;
    stalls        = 0;
    held          = 1'b0;
    held_val      = '0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_p", bus.p, 0);
    chk("rst_g", bus.g, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_release", bus.in_ready, 1);
    chk("out_valid_after_release", bus.out_valid, 0);

    // Single op: 1011 ^ 0110 = 1101, 1011 & 0110 = 0010
    bus.out_ready = 1'b1;
    send(4'b1011, 4'b0110, 1'b1, 4'b1101, 4'b0010);
    bus.in_valid = 1'b0;
    chk("single_out_valid", bus.out_valid, 1);
    @(posedge clk);
    #1;
    chk("single_then_empty", bus.out_valid, 0);
    drain();

    // Streaming: a=i, b=15-i always gives p=1111, g=0000
    stalls = 0;
    base   = n_out;
    for (int i = 0; i < 16; i++) begin
      av = 4'(i);
      bv = 4'(15 - i);
      send(av, bv, av[0], 4'b1111, 4'b0000);
    end
    bus.in_valid = 1'b0;
    chk("stream_no_stall", stalls, 0);
    drain();
    chk("stream_count", n_out - base, 16);

    // Backpressure: op0 3/5/0 -> p=6 g=1; op1 F/F/1 -> p=0 g=F; op2 8/1/1 -> p=9 g=0
    bus.out_ready = 1'b0;
    send(4'h3, 4'h5, 1'b0, 4'h6, 4'h1);
    send(4'hF, 4'hF, 1'b1, 4'h0, 4'hF);
    bus.in_valid = 1'b1;
    bus.a        = 4'h8;
    bus.b        = 4'h1;
    bus.cin      = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready_low", bus.in_ready, 0);
      chk("bp_frozen_op0", {bus.p, bus.g, bus.c0}, {4'h6, 4'h1, 1'b0});
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(4'h8, 4'h1, 1'b1, 4'h9, 4'h0);
    bus.in_valid = 1'b0;
    drain();

    // Simultaneous in/out every cycle: never fills SKID, no bubbles
    stalls = 0;
    base   = n_out;
    send(4'h1, 4'h2, 1'b0, 4'h3, 4'h0);
    send(4'hA, 4'h3, 1'b1, 4'h9, 4'h2);
    send(4'hC, 4'hC, 1'b0, 4'h0, 4'hC);
    send(4'h7, 4'h9, 1'b1, 4'hE, 4'h1);
    send(4'h5, 4'hA, 1'b0, 4'hF, 4'h0);
    send(4'hE, 4'h6, 1'b1, 4'h8, 4'h6);
    bus.in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("simul_no_stall", stalls, 0);
    chk("simul_no_bubble", n_out - base, 6);
    chk("simul_in_ready", bus.in_ready, 1);
    drain();

    // Reset mid-stream while TWO: pending entries discarded
    bus.out_ready = 1'b0;
    send(4'h2, 4'h4, 1'b1, 4'h6, 4'h0);
    send(4'h6, 4'h3, 1'b0, 4'h5, 4'h2);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_pgc", {bus.p, bus.g, bus.c0}, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_stale", bus.out_valid, 0);
    base = n_out;
    send(4'h9, 4'h5, 1'b1, 4'hC, 4'h1);
    bus.in_valid = 1'b0;
    drain();
    chk("midrst_new_only", n_out - base, 1);

    // Exhaustive a,b,cin: carries checked through the lookahead model
    base = n_out;
    for (int v = 0; v < 512; v++) begin
      av = 4'(v >> 5);
      bv = 4'(v >> 1);
      send(av, bv, v[0], av ^ bv, av & bv);
    end
    bus.in_valid = 1'b0;
    drain();
    chk("exhaustive_count", n_out - base, 512);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
